// File: rtl/multiplier_ct_taint_param.sv
// ---------------------------------------------------------------------------
// multiplier_ct_taint_param
//
// Constant-time shift-add unsigned multiplier with per-bit taint tracking.
// One multiplier bit is consumed per RUN cycle (LSB first), so every product
// takes exactly NUM_BITS RUN cycles no matter what the operands are.
//
// Build option:
//   TAINT_PRECISE_EN  defined   -> per-step, per-bit taint propagation
//                     undefined -> one sticky taint flag covering the whole
//                                  product (no per-step taint logic)
//
// Parameters:
//   NUM_BITS        operand width N (N >= 2); product width is 2N
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous reset, active-low
//   start           request, sampled only while idle
//   start_t         taint of start (control taint)
//   multiplier      operand A, captured on accept
//   multiplier_t    per-bit taint of A
//   multiplicand    operand B, captured on accept
//   multiplicand_t  per-bit taint of B
//   busy            high while running or presenting done
//   done            one-cycle pulse, product valid
//   done_t          taint of done/busy timing (start_t of that operation)
//   product         A*B, held until the next completion or reset
//   product_t       per-bit taint of product
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; operands captured on accept
// S_RUN  | NUM_BITS shift-add steps, one multiplier bit per cycle
// S_DONE | done pulse; results already loaded into the output registers
//
module multiplier_ct_taint_param #(
   parameter int NUM_BITS = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    start_t,
   input  logic [NUM_BITS-1:0]     multiplier,
   input  logic [NUM_BITS-1:0]     multiplier_t,
   input  logic [NUM_BITS-1:0]     multiplicand,
   input  logic [NUM_BITS-1:0]     multiplicand_t,
   output logic                    busy,
   output logic                    done,
   output logic                    done_t,
   output logic [2*NUM_BITS-1:0]   product,
   output logic [2*NUM_BITS-1:0]   product_t
);

   localparam int P  = 2 * NUM_BITS;
   localparam int CW = $clog2(NUM_BITS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic [CW-1:0]   count_q;
   logic [NUM_BITS-1:0] a_q;
   logic [P-1:0]    mcand_q;
   logic [P-1:0]    acc_q;
   logic            st_q;
   logic [P-1:0]    product_q;
   logic [P-1:0]    product_t_q;
   logic            done_t_q;

   logic            last_step;
   logic [P-1:0]    pp;
   logic [P-1:0]    acc_nxt;

   assign last_step = (count_q == CW'(NUM_BITS - 1));

   // Partial product is always formed and always added, even when a[0]=0.
   assign pp      = mcand_q & {P{a_q[0]}};
   assign acc_nxt = acc_q + pp;

`ifdef TAINT_PRECISE_EN
   logic [NUM_BITS-1:0] a_t_q;
   logic [P-1:0]    mcand_t_q;
   logic [P-1:0]    acc_t_q;
   // Bits at or above the weight of the multiplier bit being consumed; a
   // tainted multiplier bit of weight 2^i cannot influence product bits < i.
   logic [P-1:0]    wmask_q;
   logic [P-1:0]    pp_t;
   logic [P-1:0]    sum_t;
   logic [P-1:0]    acc_t_nxt;

   assign pp_t  = ({P{a_t_q[0]}} & wmask_q) | (mcand_t_q & {P{a_q[0]}});
   assign sum_t = acc_t_q | pp_t;

   // Carries only move upward, so taint at bit k may reach any bit j >= k.
   always_comb begin
      logic run_t;
      acc_t_nxt = '0;
      run_t     = 1'b0;
      for (int j = 0; j < P; j++) begin
         run_t        = run_t | sum_t[j];
         acc_t_nxt[j] = run_t;
      end
   end
`else
   logic            any_t_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_step) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= '0;
         a_q         <= '0;
         mcand_q     <= '0;
         acc_q       <= '0;
         st_q        <= 1'b0;
         product_q   <= '0;
         product_t_q <= '0;
         done_t_q    <= 1'b0;
`ifdef TAINT_PRECISE_EN
         a_t_q       <= '0;
         mcand_t_q   <= '0;
         acc_t_q     <= '0;
         wmask_q     <= '0;
`else
         any_t_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  count_q   <= '0;
                  a_q       <= multiplier;
                  mcand_q   <= {{NUM_BITS{1'b0}}, multiplicand};
                  acc_q     <= '0;
                  st_q      <= start_t;
`ifdef TAINT_PRECISE_EN
                  a_t_q     <= multiplier_t;
                  mcand_t_q <= {{NUM_BITS{1'b0}}, multiplicand_t};
                  acc_t_q   <= '0;
                  wmask_q   <= '1;
`else
                  any_t_q   <= (|multiplier_t) | (|multiplicand_t) | start_t;
`endif
               end
            end
            S_RUN: begin
               count_q   <= count_q + CW'(1);
               a_q       <= a_q >> 1;
               mcand_q   <= mcand_q << 1;
               acc_q     <= acc_nxt;
`ifdef TAINT_PRECISE_EN
               a_t_q     <= a_t_q >> 1;
               mcand_t_q <= mcand_t_q << 1;
               wmask_q   <= wmask_q << 1;
               acc_t_q   <= acc_t_nxt;
`endif
               if (last_step) begin
                  product_q   <= acc_nxt;
                  done_t_q    <= st_q;
`ifdef TAINT_PRECISE_EN
                  product_t_q <= acc_t_nxt;
`else
                  product_t_q <= {P{any_t_q}};
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign done_t    = done_t_q;
   assign product   = product_q;
   assign product_t = product_t_q;

endmodule

// File: tb/tb_multiplier_ct_taint_param.sv
module tb_multiplier_ct_taint_param;

   localparam int N = 7;
   localparam int P = 2 * N;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          start_t;
   logic [N-1:0]  multiplier;
   logic [N-1:0]  multiplier_t;
   logic [N-1:0]  multiplicand;
   logic [N-1:0]  multiplicand_t;
   logic          busy;
   logic          done;
   logic          done_t;
   logic [P-1:0]  product;
   logic [P-1:0]  product_t;

   multiplier_ct_taint_param #(.NUM_BITS(N)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_t        (start_t),
      .multiplier     (multiplier),
      .multiplier_t   (multiplier_t),
      .multiplicand   (multiplicand),
      .multiplicand_t (multiplicand_t),
      .busy           (busy),
      .done           (done),
      .done_t         (done_t),
      .product        (product),
      .product_t      (product_t)
   );

   typedef struct {
      logic [P-1:0] p;
      logic [P-1:0] pt;
      logic         dt;
      int           exp_edge;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   logic prev_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference taint: lowest product bit position that any tainted source can
   // reach; every bit from there upward is tainted.
   function automatic logic [P-1:0] model_pt(input logic [N-1:0] a, input logic [N-1:0] at,
                                             input logic [N-1:0] bt, input logic st);
      logic [P-1:0] ones;
      int lo;
      ones = '1;
`ifdef TAINT_PRECISE_EN
      lo = P;
      for (int i = 0; i < N; i++) begin
         if (at[i] && i < lo) lo = i;
         if (a[i])
            for (int j = 0; j < N; j++)
               if (bt[j] && (i + j) < lo) lo = i + j;
      end
      return (lo >= P) ? '0 : (ones << lo);
`else
      return ((|at) || (|bt) || st) ? ones : '0;
`endif
   endfunction

   always @(negedge clk) begin
      if (prev_done) chk("done_one_cycle", {63'd0, done}, 64'd0);
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product",   64'(product),   64'(e.p));
            chk("product_t", 64'(product_t), 64'(e.pt));
            chk("done_t",    {63'd0, done_t}, {63'd0, e.dt});
            chk("latency",   64'(edge_cnt),  64'(e.exp_edge));
         end
      end
      prev_done = done;
   end

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"},      {63'd0, busy},   64'd0);
      chk({tag, "_done"},      {63'd0, done},   64'd0);
      chk({tag, "_done_t"},    {63'd0, done_t}, 64'd0);
      chk({tag, "_product"},   64'(product),    64'd0);
      chk({tag, "_product_t"}, 64'(product_t),  64'd0);
   endtask

   // mode 0: plain; mode 1: start re-asserted at E0+3; mode 2: reset at E0+4
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] at, input logic [N-1:0] bt,
                         input logic st, input int mode);
      exp_t e;
      int e0;
      @(negedge clk);
      multiplier     = a;
      multiplicand   = b;
      multiplier_t   = at;
      multiplicand_t = bt;
      start_t        = st;
      start          = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e0 = edge_cnt;
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      e.p        = P'(a) * P'(b);
      e.pt       = model_pt(a, at, bt, st);
      e.dt       = st;
      e.exp_edge = e0 + N;
      if (mode != 2) sb.push_back(e);
      if (mode == 1) begin
         repeat (3) @(negedge clk);
         multiplier   = 7'h7F;
         multiplicand = 7'h7F;
         start        = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (mode == 2) begin
         repeat (4) @(negedge clk);
         rst_n = 1'b0;
         start = 1'b1;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         start = 1'b0;
         sb.delete();
         check_zero_outputs("midop_reset");
         repeat (N + 3) @(posedge clk);
      end
      for (int k = 0; k < 4 * N; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=pending required=done");
         sb.delete();
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      start_t        = 1'b0;
      multiplier     = '0;
      multiplier_t   = '0;
      multiplicand   = '0;
      multiplicand_t = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;

      run_op(7'd15, 7'd15, '0, '0, 1'b0, 0);
      run_op(7'd0, 7'd12, '0, '0, 1'b0, 0);
      run_op(7'd127, 7'd127, '0, '0, 1'b0, 0);
      run_op(7'd92, 7'd75, '0, '0, 1'b0, 0);
      run_op(7'd42, 7'd78, '0, '0, 1'b0, 0);
      run_op(7'd1, 7'd64, '0, 7'b1000000, 1'b0, 0);
      run_op(7'd0, 7'd12, 7'b0000001, '0, 1'b0, 0);
      run_op(7'd0, 7'd12, 7'b1000000, '0, 1'b0, 0);
      run_op(7'd3, 7'd5, '0, '0, 1'b1, 0);
      run_op(7'd2, 7'd2, '0, '0, 1'b0, 0);
      run_op(7'd5, 7'd9, '0, '0, 1'b0, 1);
      run_op(7'd33, 7'd44, 7'b0000100, '0, 1'b1, 2);
      run_op(7'd11, 7'd13, '0, '0, 1'b0, 0);

      for (int r = 0; r < 40; r++) begin
         logic [N-1:0] ra, rb, rat, rbt;
         logic rst_t;
         ra    = N'($urandom);
         rb    = N'($urandom);
         rat   = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         rbt   = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         rst_t = ($urandom_range(7) == 0);
         run_op(ra, rb, rat, rbt, rst_t, ($urandom_range(9) == 0) ? 1 : 0);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
